muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide controller for the EX stage of the MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, selected by the ALU control code produced in decode, and sequences a fixed-latency multiplier and an iterative radix-2 divider. It owns the architectural HI/LO registers and stalls the pipeline until a result is committed. MFHI/MFLO read `hi_o`/`lo_o` directly.

## Interface
Parameters:
- `MUL_LAT`, 2: total multiply stall cycles, including the accept cycle. Range 1–4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_E`  in  1  a valid instruction is in EX this cycle.
- `alu_ctr_E`  in  5  ALU control code from decode (`ALU_*` from `define.v`).
- `src_a_E`  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `src_b_E`  in  32  rt operand (divisor / multiplier).
- `flush_E`  in  1  EX flush (exception or redirect); cancels the operation.
- `stall_E`  out  1  hold IF/ID/EX; combinational.
- `busy_o`  out  1  FSM not in IDLE; registered.
- `hi_o`  out  32  architectural HI.
- `lo_o`  out  32  architectural LO.

## Operation
- Op classes, decoded from `alu_ctr_E`:
  - MUL: `ALU_SIGNED_MULT`, `ALU_UNSIGNED_MULT`.
  - DIV: `ALU_SIGNED_DIV`, `ALU_UNSIGNED_DIV`.
  - MT: `ALU_MTHI`, `ALU_MTLO`.
  - All other codes are ignored.
- Accept condition: IDLE & `valid_E` & !`flush_E` & class MUL/DIV. On accept, operands and signedness are latched.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL on MUL accept. If MUL_LAT=1, IDLE→DONE directly.
  - IDLE→DIV on DIV accept.
  - MUL→DONE when the counter reaches MUL_LAT−1.
  - DIV→DONE after 32 iterations.
  - DONE→IDLE unconditionally.
  - Any non-IDLE state → IDLE when `flush_E`=1. HI/LO are left unchanged.
- MT ops in IDLE:
  - With `valid_E` & !`flush_E`: write `src_a_E` to HI (MTHI) or LO (MTLO) at the clock edge.
  - No stall, no state change.
- Multiply:
  - 64-bit product; {HI,LO} = product.
  - Signed: both operands sign-extended to 64 bits before multiplication.
  - Unsigned: both operands zero-extended.
- Divide (restoring, one quotient bit per cycle, on operand magnitudes):
  - Signed: quotient negated if sign(a)≠sign(b); remainder takes the sign of a.
  - LO=quotient, HI=remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero: LO=0xFFFFFFFF, HI=`src_a_E` as latched. No trap. The full 32 cycles are still spent.
- `stall_E` = (IDLE & accept) | MUL | DIV.
  - Deasserted in DONE and IDLE.
  - Forced to 0 when `flush_E`=1.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `hi_o`=0, `lo_o`=0, `busy_o`=0.
  - `stall_E`=0 while `rst` is high.
- DIV: accept cycle + 32 DIV cycles = 33 stall cycles. HI/LO update at the edge ending the DONE cycle.
- MUL: MUL_LAT stall cycles, then DONE.
- The DONE cycle is when the instruction leaves EX. An MFHI/MFLO in EX on the following cycle sees the new value.
- Back-to-back MUL/DIV: the second instruction enters EX after DONE and is accepted in the next IDLE cycle. No bubble beyond DONE.
- MT op arriving during DIV/MUL cannot occur, because the pipeline is stalled. If `valid_E`+MT is seen outside IDLE, it is ignored.
- Flush and accept in the same cycle: not accepted, no stall.
- Flush in DONE: returns to IDLE, no HI/LO write.
- `rst` mid-operation: immediate return to reset values.

## Structure
- `define.v` (shared, already included by decode):
  - existing `ALU_*` codes;
  - new `MD_IDLE`, `MD_MUL`, `MD_DIV`, `MD_DONE` state encodings (2-bit);
  - `MD_DIV_ITERS`=32.
- Sub-module `div_iter`:
  - operands, signedness, start;
  - 32-cycle restoring divider producing quotient/remainder with sign fix-up;
  - no HI/LO knowledge.
- The multiplier is inferred in `muldiv_ctrl`, with a registered pipeline of depth MUL_LAT−1.

## Test plan
- Reset mid-DIV: start DIVU, assert `rst` at iteration 10 → `hi_o`=`lo_o`=0, `busy_o`=0, `stall_E`=0 immediately.
- MULT signed: a=0xFFFFFFFE (−2), b=3, MUL_LAT=2 → 2 stall cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV signed: a=−7 (0xFFFFFFF9), b=2 → 33 stall cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- Divide by zero: DIVU a=0x1234, b=0 → 33 stall cycles; LO=0xFFFFFFFF, HI=0x1234.
- Flush at DIV iteration 5 → `stall_E` drops that cycle; FSM returns to IDLE; HI/LO keep their prior values; a following MTLO 0xA5A5A5A5 updates LO in 1 cycle with no stall.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide controller:
// ALU control codes it reacts to, FSM state encodings and op-class decode.
package muldiv_ctrl_pkg;

    // ALU control codes (the HI/LO related subset of the decode encoding)
    localparam logic [4:0] ALU_SIGNED_MULT   = 5'd16;
    localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd17;
    localparam logic [4:0] ALU_SIGNED_DIV    = 5'd18;
    localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd19;
    localparam logic [4:0] ALU_MTHI          = 5'd20;
    localparam logic [4:0] ALU_MTLO          = 5'd21;

    // Number of restoring-divide iterations (one quotient bit each)
    localparam int MD_DIV_ITERS = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_DIV  = 2'd2,
        CLS_MT   = 2'd3
    } md_class_e;

    function automatic md_class_e decode_class(input logic [4:0] code);
        md_class_e cls;
        case (code)
            ALU_SIGNED_MULT, ALU_UNSIGNED_MULT: cls = CLS_MUL;
            ALU_SIGNED_DIV,  ALU_UNSIGNED_DIV:  cls = CLS_DIV;
            ALU_MTHI,        ALU_MTLO:          cls = CLS_MT;
            default:                            cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    function automatic logic is_signed_op(input logic [4:0] code);
        return (code == ALU_SIGNED_MULT) || (code == ALU_SIGNED_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div.sv
// Iterative radix-2 restoring divider: loads operand magnitudes on start,
// then produces one quotient bit per step. Sign fix-up and the
// divide-by-zero result are applied combinationally on the outputs.
module div_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;

    logic [32:0] shifted;
    logic [33:0] diff;
    logic        unused_bits;

    // Partial remainder shifted left with the next dividend bit, and trial subtract
    assign shifted     = {rem_q, quo_q[31]};
    assign diff        = {1'b0, shifted} - {2'b00, b_mag_q};
    assign unused_bits = shifted[32] ^ diff[32];

    // Load on start, otherwise one restoring iteration per step
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        b_mag_d   = b_mag_q;
        a_raw_d   = a_raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        if (start) begin
            quo_d     = (signed_i && a_i[31]) ? -a_i : a_i;
            rem_d     = '0;
            b_mag_d   = (signed_i && b_i[31]) ? -b_i : b_i;
            a_raw_d   = a_i;
            neg_quo_d = signed_i && (a_i[31] ^ b_i[31]);
            neg_rem_d = signed_i && a_i[31];
            dz_d      = (b_i == 32'd0);
        end else if (step) begin
            if (diff[33]) begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end else begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q     <= '0;
            rem_q     <= '0;
            b_mag_q   <= '0;
            a_raw_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            b_mag_q   <= b_mag_d;
            a_raw_q   <= a_raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    // Divide by zero yields all-ones quotient and the raw dividend as remainder
    assign quo_o = dz_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q);
    assign rem_o = dz_q ? a_raw_q       : (neg_rem_q ? -rem_q : rem_q);

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide controller. Owns HI/LO, sequences a pipelined
// multiplier (MUL_LAT stall cycles) and the 32-iteration divider, and stalls
// the pipeline until the result commits at the end of the DONE cycle.
// Handshake: an op is taken when valid_E is high, flush_E is low and the FSM
// is IDLE; stall_E then holds EX until the DONE cycle, where it drops and the
// instruction leaves EX while HI/LO are written on that cycle's closing edge.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_E,
    input  logic [4:0]  alu_ctr_E,
    input  logic [31:0] src_a_E,
    input  logic [31:0] src_b_E,
    input  logic        flush_E,
    output logic        stall_E,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_LAST = 5'(MD_DIV_ITERS - 1);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        op_signed_q, op_signed_d;
    logic        op_div_q, op_div_d;

    md_class_e   cls;
    logic        idle;
    logic        accept;
    logic        mt_wr;
    logic        div_start;
    logic        div_step;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [63:0] mul_a_ext, mul_b_ext, product, mul_res;

    assign cls    = decode_class(alu_ctr_E);
    assign idle   = (state_q == MD_IDLE);
    assign accept = idle && valid_E && !flush_E && (cls == CLS_MUL || cls == CLS_DIV);
    assign mt_wr  = idle && valid_E && !flush_E && (cls == CLS_MT);

    // Stall covers the accept cycle and every MUL/DIV cycle; a flush or reset kills it
    assign stall_E = !rst && !flush_E &&
                     (accept || state_q == MD_MUL || state_q == MD_DIV);

    // Multiplier on latched operands, extended according to signedness
    assign mul_a_ext = op_signed_q ? {{32{op_a_q[31]}}, op_a_q} : {32'd0, op_a_q};
    assign mul_b_ext = op_signed_q ? {{32{op_b_q[31]}}, op_b_q} : {32'd0, op_b_q};
    assign product   = mul_a_ext * mul_b_ext;

    generate
        if (MUL_LAT > 1) begin : g_mul_pipe
            logic [63:0] pipe_q [MUL_LAT-1];
            logic [63:0] pipe_d [MUL_LAT-1];

            // Product shift pipeline feeding the DONE-cycle commit
            always_comb begin
                pipe_d[0] = product;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Product pipeline registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign mul_res = pipe_q[MUL_LAT-2];
        end else begin : g_mul_comb
            assign mul_res = product;
        end
    endgenerate

    div_iter u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .step     (div_step),
        .a_i      (src_a_E),
        .b_i      (src_b_E),
        .signed_i (is_signed_op(alu_ctr_E)),
        .quo_o    (div_quo),
        .rem_o    (div_rem)
    );

    // Next-state, counter, operand latch and HI/LO write logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_signed_d = op_signed_q;
        op_div_d    = op_div_q;
        div_start   = 1'b0;
        div_step    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    op_a_d      = src_a_E;
                    op_b_d      = src_b_E;
                    op_signed_d = is_signed_op(alu_ctr_E);
                    op_div_d    = (cls == CLS_DIV);
                    if (cls == CLS_DIV) begin
                        state_d   = MD_DIV;
                        div_start = 1'b1;
                    end else if (MUL_LAT == 1) begin
                        state_d = MD_DONE;
                    end else begin
                        state_d = MD_MUL;
                        cnt_d   = 5'd1;
                    end
                end else if (mt_wr) begin
                    if (alu_ctr_E == ALU_MTHI) begin
                        hi_d = src_a_E;
                    end else begin
                        lo_d = src_a_E;
                    end
                end
            end
            MD_MUL: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == MUL_LAST) begin
                    state_d = MD_DONE;
                end
            end
            MD_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == DIV_LAST) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
                if (op_div_q) begin
                    hi_d = div_rem;
                    lo_d = div_quo;
                end else begin
                    hi_d = mul_res[63:32];
                    lo_d = mul_res[31:0];
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flush_E && state_q != MD_IDLE) begin
            state_d  = MD_IDLE;
            cnt_d    = '0;
            hi_d     = hi_q;
            lo_d     = lo_q;
            div_step = 1'b0;
        end
    end

    assign busy_d = (state_d != MD_IDLE);

    // Controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_signed_q <= 1'b0;
            op_div_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_signed_q <= op_signed_d;
            op_div_q    <= op_div_d;
        end
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors for the corner cases
// plus randomized ops compared with an arithmetic model of HI/LO and stall length.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int MUL_LAT = 2;
    localparam logic [4:0] ALU_NOP = 5'd0;

    logic        clk;
    logic        rst;
    logic        valid_E;
    logic [4:0]  alu_ctr_E;
    logic [31:0] src_a_E;
    logic [31:0] src_b_E;
    logic        flush_E;
    logic        stall_E;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_E   (valid_E),
        .alu_ctr_E (alu_ctr_E),
        .src_a_E   (src_a_E),
        .src_b_E   (src_b_E),
        .flush_E   (flush_E),
        .stall_E   (stall_E),
        .busy_o    (busy_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural reference: new HI/LO and expected stall cycles of one op
    function automatic void model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] nh, output logic [31:0] nl, output int st);
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        nh = hi;
        nl = lo;
        st = 0;
        case (code)
            ALU_SIGNED_MULT: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                {nh, nl} = sp;
                st = MUL_LAT;
            end
            ALU_UNSIGNED_MULT: begin
                up = 64'(a) * 64'(b);
                {nh, nl} = up;
                st = MUL_LAT;
            end
            ALU_SIGNED_DIV: begin
                st = 33;
                if (b == 32'd0) begin
                    nl = 32'hFFFF_FFFF;
                    nh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    nl = 32'h8000_0000;
                    nh = 32'd0;
                end else begin
                    q  = int'(a) / int'(b);
                    r  = int'(a) % int'(b);
                    nl = q;
                    nh = r;
                end
            end
            ALU_UNSIGNED_DIV: begin
                st = 33;
                if (b == 32'd0) begin
                    nl = 32'hFFFF_FFFF;
                    nh = a;
                end else begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            ALU_MTHI: nh = a;
            ALU_MTLO: nl = a;
            default: ;
        endcase
    endfunction

    // Present one op in EX, count stall cycles, then check the committed HI/LO
    task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          stalls;
        int          exp_st;
        logic [31:0] nh;
        logic [31:0] nl;
        model(code, a, b, exp_hi, exp_lo, nh, nl, exp_st);
        @(negedge clk);
        valid_E   = 1'b1;
        alu_ctr_E = code;
        src_a_E   = a;
        src_b_E   = b;
        #1;
        stalls = 0;
        while (stall_E === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stalls"}, 64'(stalls), 64'(exp_st));
        check({tag, "_busy_last"}, 64'(busy_o), 64'(exp_st > 0));
        check({tag, "_hi_hold"}, 64'(hi_o), 64'(exp_hi));
        check({tag, "_lo_hold"}, 64'(lo_o), 64'(exp_lo));
        @(negedge clk);
        valid_E   = 1'b0;
        alu_ctr_E = ALU_NOP;
        #1;
        exp_hi = nh;
        exp_lo = nl;
        check({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
        check({tag, "_busy_end"}, 64'(busy_o), 64'(0));
    endtask

    // Start an op and let it run n cycles past the accept cycle
    task automatic start_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b, input int n);
        @(negedge clk);
        valid_E   = 1'b1;
        alu_ctr_E = code;
        src_a_E   = a;
        src_b_E   = b;
        #1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [4:0]  codes [6];
        logic [4:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        int          waited;

        codes[0] = ALU_SIGNED_MULT;
        codes[1] = ALU_UNSIGNED_MULT;
        codes[2] = ALU_SIGNED_DIV;
        codes[3] = ALU_UNSIGNED_DIV;
        codes[4] = ALU_MTHI;
        codes[5] = ALU_MTLO;

        n_checks  = 0;
        n_errors  = 0;
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;
        rst       = 1'b1;
        valid_E   = 1'b1;
        alu_ctr_E = ALU_SIGNED_MULT;
        src_a_E   = 32'd5;
        src_b_E   = 32'd6;
        flush_E   = 1'b0;

        // Reset: outputs at reset values, no stall even with a MUL presented
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall_E), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_hi", 64'(hi_o), 64'(0));
        check("rst_lo", 64'(lo_o), 64'(0));
        @(negedge clk);
        rst       = 1'b0;
        valid_E   = 1'b0;
        alu_ctr_E = ALU_NOP;

        // Directed arithmetic vectors
        run_op(ALU_SIGNED_MULT,   32'hFFFF_FFFE, 32'd3, "mult");
        run_op(ALU_UNSIGNED_MULT, 32'hFFFF_FFFE, 32'd3, "multu");
        run_op(ALU_SIGNED_DIV,    32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(ALU_UNSIGNED_DIV,  32'd100,       32'd7, "divu");
        run_op(ALU_UNSIGNED_DIV,  32'h0000_1234, 32'd0, "divu_zero");
        run_op(ALU_SIGNED_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(ALU_SIGNED_DIV,    32'd7,         32'hFFFF_FFFE, "div_posneg");
        run_op(ALU_SIGNED_DIV,    32'hFFFF_FF00, 32'd0, "div_zero_s");
        run_op(5'd3,              32'hDEAD_BEEF, 32'd1, "other");

        // Flush during DIV: stall drops at once, HI/LO keep prior values
        start_op(ALU_UNSIGNED_DIV, 32'd1000, 32'd3, 5);
        check("flush_div_stall_before", 64'(stall_E), 64'(1));
        flush_E = 1'b1;
        #1;
        check("flush_div_stall", 64'(stall_E), 64'(0));
        @(negedge clk);
        flush_E   = 1'b0;
        valid_E   = 1'b0;
        alu_ctr_E = ALU_NOP;
        #1;
        check("flush_div_busy", 64'(busy_o), 64'(0));
        check("flush_div_hi", 64'(hi_o), 64'(exp_hi));
        check("flush_div_lo", 64'(lo_o), 64'(exp_lo));
        run_op(ALU_MTLO, 32'hA5A5_A5A5, 32'd0, "mtlo");

        // Flush together with a would-be accept: nothing starts
        @(negedge clk);
        valid_E   = 1'b1;
        alu_ctr_E = ALU_SIGNED_MULT;
        src_a_E   = 32'd9;
        src_b_E   = 32'd9;
        flush_E   = 1'b1;
        #1;
        check("flush_acc_stall", 64'(stall_E), 64'(0));
        @(negedge clk);
        valid_E   = 1'b0;
        flush_E   = 1'b0;
        alu_ctr_E = ALU_NOP;
        #1;
        check("flush_acc_busy", 64'(busy_o), 64'(0));
        check("flush_acc_lo", 64'(lo_o), 64'(exp_lo));

        // Flush in DONE: no HI/LO write
        start_op(ALU_UNSIGNED_MULT, 32'h0001_0000, 32'h0003_0000, 0);
        waited = 0;
        while (stall_E === 1'b1 && waited < 100) begin
            waited++;
            @(negedge clk);
            #1;
        end
        check("flush_done_stalls", 64'(waited), 64'(MUL_LAT));
        flush_E = 1'b1;
        @(negedge clk);
        flush_E   = 1'b0;
        valid_E   = 1'b0;
        alu_ctr_E = ALU_NOP;
        #1;
        check("flush_done_busy", 64'(busy_o), 64'(0));
        check("flush_done_hi", 64'(hi_o), 64'(exp_hi));
        check("flush_done_lo", 64'(lo_o), 64'(exp_lo));

        // Reset in the middle of a DIVU
        run_op(ALU_MTHI, 32'h1111_1111, 32'd0, "mthi_pre");
        start_op(ALU_UNSIGNED_DIV, 32'd12345, 32'd17, 10);
        rst = 1'b1;
        #1;
        check("rst_mid_hi", 64'(hi_o), 64'(0));
        check("rst_mid_lo", 64'(lo_o), 64'(0));
        check("rst_mid_busy", 64'(busy_o), 64'(0));
        check("rst_mid_stall", 64'(stall_E), 64'(0));
        @(negedge clk);
        rst       = 1'b0;
        valid_E   = 1'b0;
        alu_ctr_E = ALU_NOP;
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;

        // Randomized mix of ops and operand shapes
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                code = 5'($urandom_range(0, 15));
            end else begin
                code = codes[$urandom_range(0, 5)];
            end
            case ($urandom_range(0, 4))
                0: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(0, 20)); end
                1: begin a = $urandom; b = 32'd0; end
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = $urandom; b = 32'(-$urandom_range(1, 50)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(code, a, b, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
